// File: rtl/sdhci_pkg.sv
// Shared types for the SDHCI block sequencer: FSM state encoding, default widths,
// latched transfer configuration and the Block Count writable-reg pair.
package sdhci_pkg;

    localparam int unsigned BlkCntWDef = 16;
    localparam int unsigned BlkSzWDef  = 12;

    // Plain vector plus constants so legacy code can compare raw state values.
    typedef logic [2:0] sdhci_blk_seq_state_e;

    localparam sdhci_blk_seq_state_e StIdle    = 3'd0;
    localparam sdhci_blk_seq_state_e StWaitBuf = 3'd1;
    localparam sdhci_blk_seq_state_e StXfer    = 3'd2;
    localparam sdhci_blk_seq_state_e StCmd12   = 3'd3;
    localparam sdhci_blk_seq_state_e StDone    = 3'd4;

    typedef struct packed {
        logic                 dir;
        logic                 multi;
        logic                 cnt_en;
        logic                 acmd12;
        logic [BlkSzWDef-1:0] size;
    } sdhci_blk_cfg_t;

    typedef struct packed {
        logic [BlkCntWDef-1:0] d;
        logic                  de;
    } sdhci_blk_cnt_wr_t;

endpackage

// File: rtl/sdhci_block_sequencer.sv
// Block-by-block SD data transfer sequencer: buffer gating, DAT engine handshake,
// Block Count decrement, Auto CMD12 and completion/error pulses.
module sdhci_block_sequencer
    import sdhci_pkg::*;
#(
    parameter int unsigned BlkCntW = BlkCntWDef,
    parameter int unsigned BlkSzW  = BlkSzWDef
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               stop_i,
    input  logic               dir_read_i,
    input  logic               multi_block_i,
    input  logic               blk_cnt_en_i,
    input  logic               auto_cmd12_en_i,
    input  logic [BlkCntW-1:0] block_count_i,
    input  logic [BlkSzW-1:0]  block_size_i,
    input  logic               buf_rdy_i,
    output logic               blk_start_o,
    output logic [BlkSzW-1:0]  blk_len_o,
    input  logic               blk_done_i,
    input  logic               blk_err_i,
    output logic [BlkCntW-1:0] block_count_d_o,
    output logic               block_count_de_o,
    output logic               read_transfer_active_o,
    output logic               write_transfer_active_o,
    output logic               auto_cmd12_req_o,
    input  logic               auto_cmd12_ack_i,
    output logic               transfer_done_o,
    output logic               transfer_error_o
);

    sdhci_blk_seq_state_e state_q, state_d;
    sdhci_blk_cfg_t       cfg_q, cfg_d;
    sdhci_blk_cnt_wr_t    cnt_wr_q, cnt_wr_d;
    logic [BlkCntW-1:0]   remaining_q, remaining_d;
    logic                 stop_q, stop_d;
    logic                 blk_start_q, blk_start_d;
    logic                 err_q, err_d;
    logic                 rd_act_q, rd_act_d;
    logic                 wr_act_q, wr_act_d;
    logic                 last_blk;
    logic                 active_d;

    // Infinite transfers (multi without count enable) only end through stop or abort.
    assign last_blk = stop_q |
                      ((remaining_q == BlkCntW'(1)) & (cfg_q.cnt_en | ~cfg_q.multi));

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        remaining_d = remaining_q;
        stop_d      = stop_q;
        blk_start_d = 1'b0;
        cnt_wr_d    = '0;
        err_d       = 1'b0;

        if (abort_i) begin
            state_d = StIdle;
            stop_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    stop_d = 1'b0;
                    if (start_i) begin
                        cfg_d.dir    = dir_read_i;
                        cfg_d.multi  = multi_block_i;
                        cfg_d.cnt_en = blk_cnt_en_i;
                        cfg_d.acmd12 = auto_cmd12_en_i;
                        cfg_d.size   = block_size_i;
                        remaining_d  = multi_block_i ? block_count_i : BlkCntW'(1);
                        if (block_size_i == '0) begin
                            err_d = 1'b1;
                        end else if (multi_block_i & blk_cnt_en_i & (block_count_i == '0)) begin
                            state_d = StDone;
                        end else begin
                            state_d = StWaitBuf;
                        end
                    end
                end
                StWaitBuf: begin
                    if (stop_i | stop_q) begin
                        stop_d  = 1'b1;
                        state_d = StDone;
                    end else if (buf_rdy_i) begin
                        blk_start_d = 1'b1;
                        state_d     = StXfer;
                    end
                end
                StXfer: begin
                    if (stop_i) begin
                        stop_d = 1'b1;
                    end
                    if (blk_err_i) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else if (blk_done_i) begin
                        if (cfg_q.cnt_en) begin
                            remaining_d = remaining_q - BlkCntW'(1);
                            cnt_wr_d.d  = remaining_q - BlkCntW'(1);
                            cnt_wr_d.de = 1'b1;
                        end
                        if (last_blk) begin
                            state_d = (cfg_q.multi & cfg_q.cnt_en & cfg_q.acmd12 & ~stop_q) ?
                                      StCmd12 : StDone;
                        end else begin
                            state_d = StWaitBuf;
                        end
                    end
                end
                StCmd12: begin
                    if (auto_cmd12_ack_i) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Status bits follow the next state so they fall as the FSM leaves XFER.
        active_d = (state_d == StWaitBuf) | (state_d == StXfer);
        rd_act_d = active_d & cfg_d.dir;
        wr_act_d = active_d & ~cfg_d.dir;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cfg_q       <= '0;
            cnt_wr_q    <= '0;
            remaining_q <= '0;
            stop_q      <= 1'b0;
            blk_start_q <= 1'b0;
            err_q       <= 1'b0;
            rd_act_q    <= 1'b0;
            wr_act_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            cnt_wr_q    <= cnt_wr_d;
            remaining_q <= remaining_d;
            stop_q      <= stop_d;
            blk_start_q <= blk_start_d;
            err_q       <= err_d;
            rd_act_q    <= rd_act_d;
            wr_act_q    <= wr_act_d;
        end
    end

    assign blk_start_o             = blk_start_q;
    assign blk_len_o               = cfg_q.size;
    assign block_count_d_o         = cnt_wr_q.d;
    assign block_count_de_o        = cnt_wr_q.de;
    assign read_transfer_active_o  = rd_act_q;
    assign write_transfer_active_o = wr_act_q;
    assign auto_cmd12_req_o        = (state_q == StCmd12);
    assign transfer_done_o         = (state_q == StDone);
    assign transfer_error_o        = err_q;

endmodule

// File: tb/tb_sdhci_block_sequencer.sv
// Directed, table-driven bench for sdhci_block_sequencer with a few hand-written
// reset sequences.
module tb_sdhci_block_sequencer;

    localparam int unsigned CW = 16;
    localparam int unsigned SW = 12;

    // Input encoding {start, stop, abort, buf_rdy, blk_done, blk_err, cmd12_ack}
    localparam logic [6:0] N = 7'b0000000;
    localparam logic [6:0] S = 7'b1000000;
    localparam logic [6:0] P = 7'b0100000;
    localparam logic [6:0] A = 7'b0010000;
    localparam logic [6:0] R = 7'b0001000;
    localparam logic [6:0] D = 7'b0000100;
    localparam logic [6:0] E = 7'b0000010;
    localparam logic [6:0] K = 7'b0000001;
    // Output encoding {blk_start, de, rd_act, wr_act, cmd12_req, done, error}
    localparam logic [6:0] BS = 7'b1000000;
    localparam logic [6:0] DE = 7'b0100000;
    localparam logic [6:0] RA = 7'b0010000;
    localparam logic [6:0] WA = 7'b0001000;
    localparam logic [6:0] RQ = 7'b0000100;
    localparam logic [6:0] TD = 7'b0000010;
    localparam logic [6:0] TE = 7'b0000001;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0, abort_i = 1'b0, stop_i = 1'b0;
    logic          dir_read_i = 1'b0, multi_block_i = 1'b0, blk_cnt_en_i = 1'b0;
    logic          auto_cmd12_en_i = 1'b0;
    logic [CW-1:0] block_count_i = '0;
    logic [SW-1:0] block_size_i = '0;
    logic          buf_rdy_i = 1'b0, blk_done_i = 1'b0, blk_err_i = 1'b0;
    logic          auto_cmd12_ack_i = 1'b0;
    logic          blk_start_o, block_count_de_o;
    logic [SW-1:0] blk_len_o;
    logic [CW-1:0] block_count_d_o;
    logic          read_transfer_active_o, write_transfer_active_o;
    logic          auto_cmd12_req_o, transfer_done_o, transfer_error_o;

    sdhci_block_sequencer #(
        .BlkCntW(CW),
        .BlkSzW (SW)
    ) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_ni),
        .start_i                (start_i),
        .abort_i                (abort_i),
        .stop_i                 (stop_i),
        .dir_read_i             (dir_read_i),
        .multi_block_i          (multi_block_i),
        .blk_cnt_en_i           (blk_cnt_en_i),
        .auto_cmd12_en_i        (auto_cmd12_en_i),
        .block_count_i          (block_count_i),
        .block_size_i           (block_size_i),
        .buf_rdy_i              (buf_rdy_i),
        .blk_start_o            (blk_start_o),
        .blk_len_o              (blk_len_o),
        .blk_done_i             (blk_done_i),
        .blk_err_i              (blk_err_i),
        .block_count_d_o        (block_count_d_o),
        .block_count_de_o       (block_count_de_o),
        .read_transfer_active_o (read_transfer_active_o),
        .write_transfer_active_o(write_transfer_active_o),
        .auto_cmd12_req_o       (auto_cmd12_req_o),
        .auto_cmd12_ack_i       (auto_cmd12_ack_i),
        .transfer_done_o        (transfer_done_o),
        .transfer_error_o       (transfer_error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dir;
        logic          multi;
        logic          cnt_en;
        logic          acmd12;
        logic [CW-1:0] count;
        logic [SW-1:0] size;
    } cfg_t;

    typedef struct {
        int            cfg;
        logic [6:0]    in;
        logic [6:0]    exp;
        logic [CW-1:0] d;
    } vec_t;

    cfg_t cfgs[8];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [6:0] outs();
        return {blk_start_o, block_count_de_o, read_transfer_active_o, write_transfer_active_o,
                auto_cmd12_req_o, transfer_done_o, transfer_error_o};
    endfunction

    task automatic add(input int c, input logic [6:0] in, input logic [6:0] exp,
                       input logic [CW-1:0] d);
        vec_t v;
        v.cfg = c;
        v.in  = in;
        v.exp = exp;
        v.d   = d;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int c, input logic [6:0] in);
        dir_read_i      = cfgs[c].dir;
        multi_block_i   = cfgs[c].multi;
        blk_cnt_en_i    = cfgs[c].cnt_en;
        auto_cmd12_en_i = cfgs[c].acmd12;
        block_count_i   = cfgs[c].count;
        block_size_i    = cfgs[c].size;
        {start_i, stop_i, abort_i, buf_rdy_i, blk_done_i, blk_err_i, auto_cmd12_ack_i} = in;
    endtask

    task automatic step(input string name, input int c, input logic [6:0] in,
                        input logic [6:0] exp, input logic [CW-1:0] d);
        @(negedge clk);
        drive(c, in);
        @(posedge clk);
        #1;
        check({name, " outs"}, 32'(outs()), 32'(exp));
        if (exp[5]) check({name, " count_d"}, 32'(block_count_d_o), 32'(d));
        if ((exp & (RA | WA)) != '0) check({name, " blk_len"}, 32'(blk_len_o), 32'(cfgs[c].size));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        cfgs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0,      12'd512}; // single read
        cfgs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd3,      12'd512}; // multi write, 3 blocks
        cfgs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd0,      12'd64};  // count 0
        cfgs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd5,      12'd256}; // infinite read
        cfgs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd4,      12'd512}; // error on block 2
        cfgs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1,      12'd0};   // size 0
        cfgs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF,   12'd100}; // max count
        cfgs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd1,      12'd128}; // one block + CMD12

        // Single-block read
        add(0, S, RA, 0);       add(0, R, BS | RA, 0);  add(0, N, RA, 0);
        add(0, D, TD, 0);       add(0, N, N, 0);
        // Multi write, 3 blocks, Auto CMD12; stray blk_done in WAIT_BUF ignored
        add(1, S, WA, 0);       add(1, R, BS | WA, 0);  add(1, D, DE | WA, 2);
        add(1, R, BS | WA, 0);  add(1, D, DE | WA, 1);  add(1, D, WA, 0);
        add(1, R, BS | WA, 0);  add(1, D, DE | RQ, 0);  add(1, N, RQ, 0);
        add(1, K, TD, 0);       add(1, N, N, 0);
        // Count 0: straight to DONE
        add(2, S, TD, 0);       add(2, N, N, 0);
        // Infinite read stopped during block 2; stray ack in XFER ignored
        add(3, S, RA, 0);       add(3, R, BS | RA, 0);  add(3, D, RA, 0);
        add(3, R, BS | RA, 0);  add(3, K, RA, 0);       add(3, P, RA, 0);
        add(3, D, TD, 0);       add(3, N, N, 0);
        // Error on block 2 of 4
        add(4, S, WA, 0);       add(4, R, BS | WA, 0);  add(4, D, DE | WA, 3);
        add(4, R, BS | WA, 0);  add(4, E, TE, 0);       add(4, N, N, 0);
        // Zero block size
        add(5, S, TE, 0);       add(5, N, N, 0);
        // Stop in WAIT_BUF beats buf_rdy
        add(1, S, WA, 0);       add(1, P | R, TD, 0);   add(1, N, N, 0);
        // Abort together with blk_done in XFER
        add(1, S, WA, 0);       add(1, R, BS | WA, 0);  add(1, A | D, N, 0);
        add(1, N, N, 0);
        // blk_err beats blk_done
        add(1, S, WA, 0);       add(1, R, BS | WA, 0);  add(1, D | E, TE, 0);
        add(1, N, N, 0);
        // 0xFFFF counts down without wrap, then abort
        add(6, S, WA, 0);       add(6, R, BS | WA, 0);  add(6, D, DE | WA, 16'hFFFE);
        add(6, A, N, 0);        add(6, N, N, 0);

        drive(0, N);
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", 32'(outs()), 32'(N));
        check("reset blk_len", 32'(blk_len_o), 32'd0);
        check("reset count_d", 32'(block_count_d_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("row%0d", i), vecs[i].cfg, vecs[i].in, vecs[i].exp, vecs[i].d);
        end

        // Reset asserted while waiting for the CMD12 response
        step("c12 start", 7, S, WA, 0);
        step("c12 rdy", 7, R, BS | WA, 0);
        step("c12 done", 7, D, DE | RQ, 0);
        step("c12 wait", 7, N, RQ, 0);
        @(negedge clk);
        rst_ni = 1'b0;
        #2;
        check("midreset outs", 32'(outs()), 32'(N));
        check("midreset blk_len", 32'(blk_len_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        step("post start", 0, S, RA, 0);
        step("post rdy", 0, R, BS | RA, 0);
        step("post done", 0, D, TD, 0);
        step("post idle", 0, N, N, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
